// File: rtl/note_gate_ctrl.sv
// Last-note-priority key stack that drives GATE, note and velocity to one ADSR voice,
// with an optional GATE-low retrigger when a new key lands on already-held keys.
module note_gate_ctrl #(
    parameter int DEPTH         = 8,
    parameter int NOTE_W        = 7,
    parameter int VEL_W         = 7,
    parameter int RETRIG_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              all_off,
    input  logic              ev_valid,
    output logic              ev_ready,
    input  logic              ev_on,
    input  logic [NOTE_W-1:0] ev_note,
    input  logic [VEL_W-1:0]  ev_vel,
    output logic              GATE,
    output logic [NOTE_W-1:0] note,
    output logic [VEL_W-1:0]  vel,
    output logic [4:0]        held_count,
    output logic              overflow
);
    localparam int            RW       = $clog2(RETRIG_CYCLES + 1) + 1;
    localparam logic [4:0]    DEPTH_C  = 5'(DEPTH);
    localparam logic [RW-1:0] RETRIG_C = RW'(RETRIG_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_APPLY,
        S_RETRIG
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_ready;
    logic              r_gate;
    logic              r_ovf;
    logic [NOTE_W-1:0] r_note;
    logic [VEL_W-1:0]  r_vel;
    logic [4:0]        r_count;
    logic [4:0]        r_idx;
    logic              r_ev_on;
    logic              r_match;
    logic [NOTE_W-1:0] r_ev_note;
    logic [VEL_W-1:0]  r_ev_vel;
    logic [RW-1:0]     r_rcnt;
    logic [NOTE_W-1:0] r_stk_note [DEPTH];
    logic [VEL_W-1:0]  r_stk_vel  [DEPTH];

    logic [NOTE_W-1:0] w_nstk_note [DEPTH];
    logic [VEL_W-1:0]  w_nstk_vel  [DEPTH];
    logic              w_hs;
    logic              w_scan_end;
    logic              w_scan_hit;
    logic              w_full;
    logic              w_shift;
    logic              w_rm_top;
    logic              w_retrig;
    logic [NOTE_W-1:0] w_idx_note;
    logic [NOTE_W-1:0] w_top2_note;
    logic [VEL_W-1:0]  w_top2_vel;
    logic [4:0]        w_rm;
    logic [4:0]        w_top;
    logic [4:0]        w_ncount;

    assign ev_ready   = r_ready;
    assign GATE       = r_gate;
    assign note       = r_note;
    assign vel        = r_vel;
    assign held_count = r_count;
    assign overflow   = r_ovf;

    assign w_hs       = (r_state == S_IDLE) & r_ready & ev_valid;
    assign w_scan_end = (r_idx >= r_count);
    assign w_scan_hit = !w_scan_end && (w_idx_note == r_ev_note);
    assign w_full     = (r_count == DEPTH_C);
    // A removal (matched entry, or the oldest entry when full) shifts the upper entries down.
    assign w_shift    = r_match | (r_ev_on & w_full);
    assign w_rm       = r_match ? r_idx : 5'd0;
    assign w_top      = (r_ev_on & (r_match | w_full)) ? r_count - 5'd1 : r_count;
    assign w_rm_top   = r_match & (r_idx == r_count - 5'd1);
    assign w_retrig   = r_ev_on & (r_count != 5'd0) & (RETRIG_CYCLES > 0);

    always_comb begin
        w_idx_note  = '0;
        w_top2_note = '0;
        w_top2_vel  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_idx == 5'(i)) begin
                w_idx_note = r_stk_note[i];
            end
            if (r_count - 5'd2 == 5'(i)) begin
                w_top2_note = r_stk_note[i];
                w_top2_vel  = r_stk_vel[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_nstk_note[i] = r_stk_note[i];
            w_nstk_vel[i]  = r_stk_vel[i];
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (w_shift && (5'(i) >= w_rm)) begin
                w_nstk_note[i] = r_stk_note[i+1];
                w_nstk_vel[i]  = r_stk_vel[i+1];
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (r_ev_on && (5'(i) == w_top)) begin
                w_nstk_note[i] = r_ev_note;
                w_nstk_vel[i]  = r_ev_vel;
            end
        end
    end

    always_comb begin
        if (r_ev_on) begin
            w_ncount = (r_match || w_full) ? r_count : r_count + 5'd1;
        end else begin
            w_ncount = r_match ? r_count - 5'd1 : r_count;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_hs) w_state_nxt = S_SCAN;
            S_SCAN:   if (w_scan_end || w_scan_hit) w_state_nxt = S_APPLY;
            S_APPLY:  w_state_nxt = w_retrig ? S_RETRIG : S_IDLE;
            S_RETRIG: if (r_rcnt <= RW'(1)) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
        if (all_off) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Stack storage is only meaningful below r_count, so it carries no reset.
    always_ff @(posedge clk) begin
        if (r_state == S_APPLY && !all_off) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stk_note[i] <= w_nstk_note[i];
                r_stk_vel[i]  <= w_nstk_vel[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ready <= 1'b0;
            r_gate  <= 1'b0;
            r_ovf   <= 1'b0;
            r_note  <= '0;
            r_vel   <= '0;
            r_count <= '0;
            r_idx   <= '0;
            r_rcnt  <= '0;
            r_match <= 1'b0;
        end else begin
            r_ovf   <= 1'b0;
            r_ready <= (w_state_nxt == S_IDLE) && !all_off;
            if (all_off) begin
                r_count <= '0;
                r_gate  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_hs) begin
                            // A zero-velocity note-on is a note-off.
                            r_ev_on   <= ev_on && (ev_vel != '0);
                            r_ev_note <= ev_note;
                            r_ev_vel  <= ev_vel;
                            r_idx     <= '0;
                        end
                    end
                    S_SCAN: begin
                        r_match <= w_scan_hit;
                        if (!(w_scan_end || w_scan_hit)) begin
                            r_idx <= r_idx + 5'd1;
                        end
                    end
                    S_APPLY: begin
                        r_count <= w_ncount;
                        if (r_ev_on) begin
                            r_note <= r_ev_note;
                            r_vel  <= r_ev_vel;
                            r_ovf  <= !r_match && w_full;
                            if (w_retrig) begin
                                r_gate <= 1'b0;
                                r_rcnt <= RETRIG_C;
                            end else begin
                                r_gate <= 1'b1;
                            end
                        end else if (r_match) begin
                            if (r_count == 5'd1) begin
                                r_gate <= 1'b0;
                            end else if (w_rm_top) begin
                                r_note <= w_top2_note;
                                r_vel  <= w_top2_vel;
                            end
                        end
                    end
                    S_RETRIG: begin
                        if (r_rcnt <= RW'(1)) begin
                            r_gate <= 1'b1;
                        end else begin
                            r_rcnt <= r_rcnt - RW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_note_gate_ctrl.sv
// Directed bench for note_gate_ctrl: one retriggering instance and one legato instance.
module tb_note_gate_ctrl;
    logic       clk = 1'b0;
    logic       rst_n, all_off, ev_on;
    logic       ev_valid_a, ev_valid_b;
    logic [6:0] ev_note, ev_vel;

    logic       ev_ready_a, GATE_a, ovf_a;
    logic [6:0] note_a, vel_a;
    logic [4:0] held_a;
    logic       ev_ready_b, GATE_b, ovf_b;
    logic [6:0] note_b, vel_b;
    logic [4:0] held_b;

    int total = 0;
    int bad   = 0;

    always #10 clk = ~clk;

    note_gate_ctrl #(.DEPTH(8), .NOTE_W(7), .VEL_W(7), .RETRIG_CYCLES(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .all_off(all_off), .ev_valid(ev_valid_a), .ev_ready(ev_ready_a),
        .ev_on(ev_on), .ev_note(ev_note), .ev_vel(ev_vel), .GATE(GATE_a), .note(note_a),
        .vel(vel_a), .held_count(held_a), .overflow(ovf_a)
    );

    note_gate_ctrl #(.DEPTH(8), .NOTE_W(7), .VEL_W(7), .RETRIG_CYCLES(0)) u_leg (
        .clk(clk), .rst_n(rst_n), .all_off(all_off), .ev_valid(ev_valid_b), .ev_ready(ev_ready_b),
        .ev_on(ev_on), .ev_note(ev_note), .ev_vel(ev_vel), .GATE(GATE_b), .note(note_b),
        .vel(vel_b), .held_count(held_b), .overflow(ovf_b)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Holds valid until the selected instance is ready, returns 1 time unit after the handshake edge.
    task automatic send(input bit which, input bit on, input int n, input int v);
        int w;
        w = 0;
        ev_on   = on;
        ev_note = 7'(n);
        ev_vel  = 7'(v);
        if (which) ev_valid_b = 1'b1; else ev_valid_a = 1'b1;
        while (((which ? ev_ready_b : ev_ready_a) !== 1'b1) && w < 60) begin
            @(posedge clk); #1; w++;
        end
        if ((which ? ev_ready_b : ev_ready_a) !== 1'b1) begin
            total++; bad++;
            $display("FAIL send_timeout ready=0 required=1");
        end else begin
            @(posedge clk); #1;
        end
        ev_valid_a = 1'b0;
        ev_valid_b = 1'b0;
    endtask

    task automatic wait_idle(input bit which, output int ovf_n, output int low_n);
        int w;
        w = 0; ovf_n = 0; low_n = 0;
        do begin
            @(posedge clk); #1; w++;
            if (which ? ovf_b : ovf_a) ovf_n++;
            if (!(which ? GATE_b : GATE_a)) low_n++;
        end while (!(which ? ev_ready_b : ev_ready_a) && w < 60);
        if (!(which ? ev_ready_b : ev_ready_a)) begin
            total++; bad++;
            $display("FAIL idle_timeout ready=0 required=1");
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; all_off = 1'b0; ev_on = 1'b0; ev_note = '0; ev_vel = '0;
        ev_valid_a = 1'b0; ev_valid_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (ev_ready_a !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", ev_ready_a); end
        total++; if (GATE_a !== 1'b0) begin bad++; $display("FAIL reset_gate got=%b want=0", GATE_a); end
        total++; if (note_a !== 7'd0 || vel_a !== 7'd0) begin bad++; $display("FAIL reset_note_vel got=%0d/%0d want=0/0", note_a, vel_a); end
        total++; if (held_a !== 5'd0 || ovf_a !== 1'b0) begin bad++; $display("FAIL reset_count_ovf got=%0d/%b want=0/0", held_a, ovf_a); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (ev_ready_a !== 1'b1 || ev_ready_b !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b%b want=11", ev_ready_a, ev_ready_b); end
    endtask

    task automatic test_first_note();
        send(0, 1, 60, 100);
        total++; if (ev_ready_a !== 1'b0) begin bad++; $display("FAIL first_ready_drop got=%b want=0", ev_ready_a); end
        @(posedge clk); #1;
        total++; if (GATE_a !== 1'b0) begin bad++; $display("FAIL first_gate_early got=%b want=0", GATE_a); end
        @(posedge clk); #1;
        total++; if (GATE_a !== 1'b1 || note_a !== 7'd60 || vel_a !== 7'd100) begin
            bad++; $display("FAIL first_outputs got=%b/%0d/%0d want=1/60/100", GATE_a, note_a, vel_a); end
        total++; if (held_a !== 5'd1 || ev_ready_a !== 1'b1) begin
            bad++; $display("FAIL first_count_ready got=%0d/%b want=1/1", held_a, ev_ready_a); end
    endtask

    task automatic test_retrig();
        logic       g [8];
        logic [6:0] nt [8];
        int         lows;
        send(0, 1, 64, 80);
        lows = 0;
        for (int j = 0; j < 8; j++) begin
            @(posedge clk); #1;
            g[j] = GATE_a; nt[j] = note_a;
            if (!GATE_a) lows++;
        end
        total++; if (g[1] !== 1'b1 || nt[1] !== 7'd60) begin bad++; $display("FAIL retrig_pre got=%b/%0d want=1/60", g[1], nt[1]); end
        total++; if (g[2] !== 1'b0 || nt[2] !== 7'd64) begin bad++; $display("FAIL retrig_apply got=%b/%0d want=0/64", g[2], nt[2]); end
        total++; if (g[3] !== 1'b0 || g[4] !== 1'b1) begin bad++; $display("FAIL retrig_shape got=%b%b want=01", g[3], g[4]); end
        total++; if (lows != 2) begin bad++; $display("FAIL retrig_low_cycles got=%0d want=2", lows); end
        total++; if (vel_a !== 7'd80 || held_a !== 5'd2) begin bad++; $display("FAIL retrig_vel_count got=%0d/%0d want=80/2", vel_a, held_a); end
    endtask

    task automatic test_legato_on();
        int o, l;
        send(1, 1, 60, 100);
        wait_idle(1, o, l);
        send(1, 1, 64, 80);
        wait_idle(1, o, l);
        total++; if (l != 0) begin bad++; $display("FAIL legato_gate_low got=%0d want=0", l); end
        total++; if (note_b !== 7'd64 || vel_b !== 7'd80 || held_b !== 5'd2) begin
            bad++; $display("FAIL legato_outputs got=%0d/%0d/%0d want=64/80/2", note_b, vel_b, held_b); end
    endtask

    task automatic test_note_off();
        int o, l;
        send(0, 1, 67, 90);
        wait_idle(0, o, l);
        send(0, 0, 67, 0);
        wait_idle(0, o, l);
        total++; if (l != 0 || GATE_a !== 1'b1) begin bad++; $display("FAIL off_top_gate lows=%0d gate=%b want=0/1", l, GATE_a); end
        total++; if (note_a !== 7'd64 || vel_a !== 7'd80 || held_a !== 5'd2) begin
            bad++; $display("FAIL off_top_restore got=%0d/%0d/%0d want=64/80/2", note_a, vel_a, held_a); end
        send(0, 0, 60, 0);
        wait_idle(0, o, l);
        total++; if (note_a !== 7'd64 || GATE_a !== 1'b1 || held_a !== 5'd1) begin
            bad++; $display("FAIL off_nontop got=%0d/%b/%0d want=64/1/1", note_a, GATE_a, held_a); end
        send(0, 0, 64, 0);
        wait_idle(0, o, l);
        total++; if (GATE_a !== 1'b0 || note_a !== 7'd64 || vel_a !== 7'd80 || held_a !== 5'd0) begin
            bad++; $display("FAIL off_last got=%b/%0d/%0d/%0d want=0/64/80/0", GATE_a, note_a, vel_a, held_a); end
    endtask

    task automatic test_overflow();
        int o, l;
        for (int i = 0; i < 8; i++) begin
            send(0, 1, 60 + i, 10 + i);
            wait_idle(0, o, l);
        end
        total++; if (held_a !== 5'd8) begin bad++; $display("FAIL ovf_fill got=%0d want=8", held_a); end
        send(0, 1, 70, 90);
        wait_idle(0, o, l);
        total++; if (o != 1) begin bad++; $display("FAIL ovf_pulse got=%0d want=1", o); end
        total++; if (held_a !== 5'd8 || note_a !== 7'd70) begin bad++; $display("FAIL ovf_state got=%0d/%0d want=8/70", held_a, note_a); end
        send(0, 0, 60, 0);
        wait_idle(0, o, l);
        total++; if (held_a !== 5'd8 || note_a !== 7'd70 || GATE_a !== 1'b1) begin
            bad++; $display("FAIL ovf_dropped_off got=%0d/%0d/%b want=8/70/1", held_a, note_a, GATE_a); end
        send(0, 1, 62, 0);
        wait_idle(0, o, l);
        total++; if (held_a !== 5'd7 || note_a !== 7'd70) begin bad++; $display("FAIL vel0_off got=%0d/%0d want=7/70", held_a, note_a); end
        send(0, 0, 70, 0);
        wait_idle(0, o, l);
        total++; if (note_a !== 7'd67 || vel_a !== 7'd17 || held_a !== 5'd6 || GATE_a !== 1'b1) begin
            bad++; $display("FAIL ovf_new_top got=%0d/%0d/%0d/%b want=67/17/6/1", note_a, vel_a, held_a, GATE_a); end
    endtask

    task automatic test_all_off();
        int o, l, w;
        send(0, 1, 80, 50);
        w = 0;
        while (GATE_a === 1'b1 && w < 40) begin @(posedge clk); #1; w++; end
        total++; if (GATE_a !== 1'b0) begin bad++; $display("FAIL alloff_enter_retrig gate=%b want=0", GATE_a); end
        all_off = 1'b1;
        @(posedge clk); #1;
        total++; if (GATE_a !== 1'b0 || held_a !== 5'd0 || ev_ready_a !== 1'b0) begin
            bad++; $display("FAIL alloff_clear got=%b/%0d/%b want=0/0/0", GATE_a, held_a, ev_ready_a); end
        total++; if (note_a !== 7'd80 || vel_a !== 7'd50) begin bad++; $display("FAIL alloff_hold got=%0d/%0d want=80/50", note_a, vel_a); end
        @(posedge clk); #1;
        total++; if (ev_ready_a !== 1'b0 || GATE_a !== 1'b0) begin bad++; $display("FAIL alloff_held got=%b/%b want=0/0", ev_ready_a, GATE_a); end
        all_off = 1'b0;
        @(posedge clk); #1;
        total++; if (ev_ready_a !== 1'b1) begin bad++; $display("FAIL alloff_release_ready got=%b want=1", ev_ready_a); end
        send(0, 1, 50, 40);
        wait_idle(0, o, l);
        total++; if (GATE_a !== 1'b1 || note_a !== 7'd50 || held_a !== 5'd1 || l != 1) begin
            bad++; $display("FAIL alloff_fresh got=%b/%0d/%0d lows=%0d want=1/50/1/1", GATE_a, note_a, held_a, l); end
    endtask

    task automatic test_reset_in_scan();
        int o, l;
        send(0, 1, 51, 60);
        rst_n = 1'b0;
        @(posedge clk); #1;
        total++; if (GATE_a !== 1'b0 || held_a !== 5'd0 || ev_ready_a !== 1'b0) begin
            bad++; $display("FAIL scanrst_clear got=%b/%0d/%b want=0/0/0", GATE_a, held_a, ev_ready_a); end
        total++; if (note_a !== 7'd0 || vel_a !== 7'd0) begin bad++; $display("FAIL scanrst_note got=%0d/%0d want=0/0", note_a, vel_a); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (ev_ready_a !== 1'b1) begin bad++; $display("FAIL scanrst_ready got=%b want=1", ev_ready_a); end
        send(0, 1, 52, 33);
        wait_idle(0, o, l);
        total++; if (GATE_a !== 1'b1 || note_a !== 7'd52 || vel_a !== 7'd33 || held_a !== 5'd1) begin
            bad++; $display("FAIL scanrst_fresh got=%b/%0d/%0d/%0d want=1/52/33/1", GATE_a, note_a, vel_a, held_a); end
    endtask

    task automatic test_back_to_back();
        int  mq_note[$];
        int  mq_vel[$];
        int  o, l, n, v, f;
        bit  on;
        all_off = 1'b1;
        @(posedge clk); #1;
        all_off = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k <= 60; k++) begin
            on = ($urandom_range(0, 9) < 6);
            n  = 40 + $urandom_range(0, 9);
            v  = ($urandom_range(0, 12) == 0) ? 0 : $urandom_range(1, 127);
            if (k < 60) send(0, on, n, v);
            else        wait_idle(0, o, l);
            total++; if (held_a !== 5'(mq_note.size())) begin
                bad++; $display("FAIL b2b_count ev=%0d got=%0d want=%0d", k, held_a, mq_note.size()); end
            total++; if (GATE_a !== (mq_note.size() > 0)) begin
                bad++; $display("FAIL b2b_gate ev=%0d got=%b want=%b", k, GATE_a, mq_note.size() > 0); end
            if (mq_note.size() > 0) begin
                total++; if (note_a !== 7'(mq_note[$]) || vel_a !== 7'(mq_vel[$])) begin
                    bad++; $display("FAIL b2b_top ev=%0d got=%0d/%0d want=%0d/%0d", k, note_a, vel_a, mq_note[$], mq_vel[$]); end
            end
            if (k < 60) begin
                f = -1;
                for (int i = 0; i < mq_note.size(); i++) if (mq_note[i] == n) f = i;
                if (on && v != 0) begin
                    if (f >= 0) begin
                        mq_note.delete(f); mq_vel.delete(f);
                    end else if (mq_note.size() == 8) begin
                        mq_note.delete(0); mq_vel.delete(0);
                    end
                    mq_note.push_back(n); mq_vel.push_back(v);
                end else if (f >= 0) begin
                    mq_note.delete(f); mq_vel.delete(f);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_note();
        test_retrig();
        test_legato_on();
        test_note_off();
        test_overflow();
        test_all_off();
        test_reset_in_scan();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
